pc_sequencer: RTL and testbench

Multi-cycle fetch/execute sequencer for the LEGv8 datapath. It owns the program counter register and steps each instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK, with ready handshakes to instruction and data memory. It resolves conditional and unconditional branches once per instruction using the same next-PC rule as the single-cycle datapath. It sits between the control unit (decode signals in) and the memories and register file (requests and enables out).

---
 rtl/pc_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_pc_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Multi-cycle LEGv8 fetch/execute sequencer: owns the PC, steps each instruction
// through FETCH..WRITEBACK with memory ready handshakes, and resolves branches at retire.
module pc_sequencer #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Halt,
  output logic        IMemReq,
  output logic [63:0] IMemAddr,
  input  logic        IMemReady,
  input  logic [31:0] Instruction,
  output logic [31:0] InstrReg,
  input  logic        Branch,
  input  logic        Uncondbranch,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        RegWrite,
  input  logic        ALUZero,
  input  logic [63:0] SignExtImm64,
  output logic        DMemReq,
  input  logic        DMemReady,
  output logic        RegWriteEn,
  output logic [63:0] CurrentPC,
  output logic [2:0]  State,
  output logic [31:0] InstrCount
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH     = 3'd1;
  localparam logic [2:0] S_DECODE    = 3'd2;
  localparam logic [2:0] S_EXECUTE   = 3'd3;
  localparam logic [2:0] S_MEMORY    = 3'd4;
  localparam logic [2:0] S_WRITEBACK = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] count_q, count_d;
  logic        taken_q, taken_d;
  logic [63:0] target_q, target_d;
  logic        reg_wr_q, reg_wr_d;

  logic        retire_s;
  logic [2:0]  retire_state_s;
  logic        exec_taken_s;
  logic [63:0] exec_target_s;
  logic        taken_s;
  logic [63:0] target_s;

  assign exec_taken_s   = Uncondbranch | (Branch & ALUZero);
  assign exec_target_s  = pc_q + {SignExtImm64[61:0], 2'b00};
  assign retire_state_s = Halt ? S_IDLE : S_FETCH;

  // A branch-class instruction retires out of EXECUTE, before its decision is latched.
  assign taken_s  = (state_q == S_EXECUTE) ? exec_taken_s  : taken_q;
  assign target_s = (state_q == S_EXECUTE) ? exec_target_s : target_q;

  // State register and all sequencer state; Reset aborts any instruction in flight.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      instr_q  <= 32'd0;
      count_q  <= 32'd0;
      taken_q  <= 1'b0;
      target_q <= 64'd0;
      reg_wr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      count_q  <= count_d;
      taken_q  <= taken_d;
      target_q <= target_d;
      reg_wr_q <= reg_wr_d;
    end
  end

  // Next-state logic; retire_s marks the edge that leaves an instruction's last state.
  always_comb begin
    state_d  = state_q;
    retire_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!Halt) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        if (IMemReady) begin
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        if (MemRead | MemWrite) begin
          state_d = S_MEMORY;
        end else if (RegWrite) begin
          state_d = S_WRITEBACK;
        end else begin
          state_d  = retire_state_s;
          retire_s = 1'b1;
        end
      end
      S_MEMORY: begin
        if (!DMemReady) begin
          state_d = S_MEMORY;
        end else if (reg_wr_q) begin
          state_d = S_WRITEBACK;
        end else begin
          state_d  = retire_state_s;
          retire_s = 1'b1;
        end
      end
      S_WRITEBACK: begin
        state_d  = retire_state_s;
        retire_s = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Datapath next values: instruction latch, EXECUTE decode capture, retire PC/count update.
  always_comb begin
    pc_d     = pc_q;
    instr_d  = instr_q;
    count_d  = count_q;
    taken_d  = taken_q;
    target_d = target_q;
    reg_wr_d = reg_wr_q;
    if ((state_q == S_FETCH) && IMemReady) begin
      instr_d = Instruction;
    end else begin
      instr_d = instr_q;
    end
    if (state_q == S_EXECUTE) begin
      taken_d  = exec_taken_s;
      target_d = exec_target_s;
      reg_wr_d = RegWrite;
    end else begin
      taken_d  = taken_q;
      target_d = target_q;
      reg_wr_d = reg_wr_q;
    end
    if (retire_s) begin
      pc_d    = taken_s ? target_s : (pc_q + 64'd4);
      count_d = count_q + 32'd1;
    end else begin
      pc_d    = pc_q;
      count_d = count_q;
    end
  end

  // Moore strobes decoded from the state register only.
  always_comb begin
    IMemReq    = 1'b0;
    DMemReq    = 1'b0;
    RegWriteEn = 1'b0;
    case (state_q)
      S_FETCH:     IMemReq    = 1'b1;
      S_MEMORY:    DMemReq    = 1'b1;
      S_WRITEBACK: RegWriteEn = 1'b1;
      default: begin
        IMemReq    = 1'b0;
        DMemReq    = 1'b0;
        RegWriteEn = 1'b0;
      end
    endcase
  end

  assign IMemAddr   = pc_q;
  assign CurrentPC  = pc_q;
  assign InstrReg   = instr_q;
  assign State      = state_q;
  assign InstrCount = count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: walks a hand-computed instruction sequence and
// checks state traces, handshake lengths, PC updates, retire count and async reset.
module tb_pc_sequencer;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        Halt;
  logic        IMemReq;
  logic [63:0] IMemAddr;
  logic        IMemReady;
  logic [31:0] Instruction;
  logic [31:0] InstrReg;
  logic        Branch, Uncondbranch, MemRead, MemWrite, RegWrite, ALUZero;
  logic [63:0] SignExtImm64;
  logic        DMemReq;
  logic        DMemReady;
  logic        RegWriteEn;
  logic [63:0] CurrentPC;
  logic [2:0]  State;
  logic [31:0] InstrCount;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;
  logic [63:0] cur_pc = 64'h0;

  pc_sequencer dut (
    .CLK(CLK), .Reset(Reset), .Halt(Halt),
    .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemReady(IMemReady),
    .Instruction(Instruction), .InstrReg(InstrReg),
    .Branch(Branch), .Uncondbranch(Uncondbranch), .MemRead(MemRead),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .ALUZero(ALUZero),
    .SignExtImm64(SignExtImm64), .DMemReq(DMemReq), .DMemReady(DMemReady),
    .RegWriteEn(RegWriteEn), .CurrentPC(CurrentPC), .State(State),
    .InstrCount(InstrCount)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Runs one instruction from FETCH entry to retire; ready inputs are held high
  // outside their request states, and decode inputs are inverted after EXECUTE.
  task automatic run_instr(input string tag,
                           input logic br, input logic ub, input logic mr,
                           input logic mw, input logic rw, input logic z,
                           input logic [63:0] imm, input int iw, input int dw,
                           input logic halt_mem, input logic [31:0] iword,
                           input logic [63:0] exp_pc, input logic [63:0] exp_trace,
                           input int exp_cycles);
    logic [63:0] trace;
    logic [2:0]  prev;
    int cyc, ic, dc, wc, ov;
    chk({tag, " start state"}, 64'(State), 64'd1);
    chk({tag, " fetch addr"}, IMemAddr, cur_pc);
    Branch = br; Uncondbranch = ub; MemRead = mr; MemWrite = mw;
    RegWrite = rw; ALUZero = z; SignExtImm64 = imm;
    trace = 64'(State);
    cyc = 0; ic = 0; dc = 0; wc = 0; ov = 0;
    while (cyc < 40) begin
      if (IMemReq) ic++;
      if (DMemReq) dc++;
      if (RegWriteEn) wc++;
      if (IMemReq && DMemReq) ov++;
      IMemReady   = (State == 3'd1) ? (ic > iw) : 1'b1;
      Instruction = ((State == 3'd1) && (ic > iw)) ? iword : 32'hDEAD_BEEF;
      DMemReady   = (State == 3'd4) ? (dc > dw) : 1'b1;
      if (State == 3'd4 || State == 3'd5) begin
        Branch = ~br; Uncondbranch = ~ub; MemRead = ~mr; MemWrite = ~mw;
        RegWrite = ~rw; ALUZero = ~z; SignExtImm64 = ~imm;
      end
      if (halt_mem && State == 3'd4) Halt = 1'b1;
      prev = State;
      step();
      cyc++;
      trace = (trace << 4) | 64'(State);
      if ((State == 3'd1 || State == 3'd0) && prev != 3'd1) break;
    end
    exp_cnt++;
    cur_pc = exp_pc;
    chk({tag, " trace"}, trace, exp_trace);
    chk({tag, " cycles"}, 64'(cyc), 64'(exp_cycles));
    chk({tag, " imemreq cycles"}, 64'(ic), 64'(iw + 1));
    chk({tag, " dmemreq cycles"}, 64'(dc), (mr | mw) ? 64'(dw + 1) : 64'd0);
    chk({tag, " regwriteen cycles"}, 64'(wc), rw ? 64'd1 : 64'd0);
    chk({tag, " req overlap"}, 64'(ov), 64'd0);
    chk({tag, " pc"}, CurrentPC, exp_pc);
    chk({tag, " count"}, 64'(InstrCount), 64'(exp_cnt));
    chk({tag, " instrreg"}, 64'(InstrReg), 64'(iword));
  endtask

  initial begin
    Reset = 1'b1; Halt = 1'b1; IMemReady = 1'b0; DMemReady = 1'b0;
    Instruction = 32'h0; Branch = 1'b0; Uncondbranch = 1'b0; MemRead = 1'b0;
    MemWrite = 1'b0; RegWrite = 1'b0; ALUZero = 1'b0; SignExtImm64 = 64'h0;
    #12;
    chk("rst state", 64'(State), 64'd0);
    chk("rst pc", CurrentPC, 64'h0);
    chk("rst imemaddr", IMemAddr, 64'h0);
    chk("rst instrreg", 64'(InstrReg), 64'h0);
    chk("rst reqs", {61'd0, IMemReq, DMemReq, RegWriteEn}, 64'd0);
    chk("rst count", 64'(InstrCount), 64'd0);

    step();
    Reset = 1'b0;
    step();
    chk("halt idle 1", 64'(State), 64'd0);
    step();
    chk("halt idle 2", 64'(State), 64'd0);
    chk("idle imemreq", 64'(IMemReq), 64'd0);
    Halt = 1'b0;
    step();

    run_instr("add",  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'd0, 0, 0, 1'b0,
              32'h8B02_0020, 64'h4, 64'h12351, 4);
    run_instr("b+63", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'd63, 0, 0, 1'b0,
              32'h1400_003F, 64'h100, 64'h1231, 3);
    run_instr("cbz taken", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'd3, 0, 0, 1'b0,
              32'hB400_0060, 64'h10C, 64'h1231, 3);
    run_instr("b-3",  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 0, 0, 1'b0,
              32'h17FF_FFFD, 64'h100, 64'h1231, 3);
    run_instr("cbz not taken", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd3, 0, 0, 1'b0,
              32'hB400_0061, 64'h104, 64'h1231, 3);
    run_instr("b-61", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFC3, 0, 0, 1'b0,
              32'h17FF_FFC3, 64'h10, 64'h1231, 3);
    run_instr("b-4",  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 1'b0,
              32'h17FF_FFFC, 64'h0, 64'h1231, 3);
    run_instr("b-1 wrap", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 1'b0,
              32'h17FF_FFFF, 64'hFFFF_FFFF_FFFF_FFFC, 64'h1231, 3);
    run_instr("ldur waits", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 64'd0, 2, 3, 1'b0,
              32'hF840_0041, 64'h0, 64'h111_2344_4451, 10);
    run_instr("stur halt", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 0, 0, 1'b1,
              32'hF800_0041, 64'h4, 64'h12340, 4);

    for (int i = 0; i < 3; i++) begin
      step();
      chk("parked idle", {60'd0, State, IMemReq}, 64'd0);
    end
    Halt = 1'b0;
    step();
    run_instr("b+15", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'd15, 0, 0, 1'b0,
              32'h1400_000F, 64'h40, 64'h1231, 3);

    // Abort an LDUR stalled in MEMORY with an asynchronous reset.
    Branch = 1'b0; Uncondbranch = 1'b0; MemRead = 1'b1; MemWrite = 1'b0;
    RegWrite = 1'b1; IMemReady = 1'b1; DMemReady = 1'b0; Instruction = 32'h1234_5678;
    chk("abort fetch addr", IMemAddr, 64'h40);
    step();
    step();
    step();
    chk("abort in memory", 64'(State), 64'd4);
    chk("abort dmemreq high", 64'(DMemReq), 64'd1);
    #2;
    Reset = 1'b1;
    #1;
    chk("abort dmemreq async", 64'(DMemReq), 64'd0);
    chk("abort state", 64'(State), 64'd0);
    chk("abort pc", CurrentPC, 64'h0);
    chk("abort count", 64'(InstrCount), 64'd0);
    #10;
    Reset = 1'b0;
    MemRead = 1'b0; RegWrite = 1'b0;
    step();
    chk("restart state", 64'(State), 64'd1);
    chk("restart imemaddr", IMemAddr, 64'h0);
    chk("restart imemreq", 64'(IMemReq), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
